// File: rtl/hdmi_packet_pkg.sv
// Types and constants shared between the HDMI packet scheduler and its arbiter.
package hdmi_packet_pkg;

  typedef enum logic [2:0] {
    PKT_NULL   = 3'd0,
    PKT_ACR    = 3'd1,
    PKT_SAMPLE = 3'd2,
    PKT_AVI    = 3'd3,
    PKT_AIF    = 3'd4,
    PKT_SPD    = 3'd5
  } packet_id_t;

  localparam int HEADER_W  = 24;
  localparam int SUB_W     = 56;
  localparam int SUB_COUNT = 4;
  localparam int NUM_SRC   = 5;

  // Bit positions in the request/grant vectors {spd, aif, avi, sample, acr}
  localparam int G_ACR = 0;
  localparam int G_SMP = 1;
  localparam int G_AVI = 2;
  localparam int G_AIF = 3;
  localparam int G_SPD = 4;

  localparam logic [HEADER_W-1:0] NULL_HEADER = '0;

  typedef logic [SUB_COUNT-1:0][SUB_W-1:0] sub_arr_t;

  function automatic packet_id_t id_from_grant(input logic [NUM_SRC-1:0] g);
    if (g[G_ACR])      return PKT_ACR;
    else if (g[G_SMP]) return PKT_SAMPLE;
    else if (g[G_AVI]) return PKT_AVI;
    else if (g[G_AIF]) return PKT_AIF;
    else if (g[G_SPD]) return PKT_SPD;
    else               return PKT_NULL;
  endfunction

endpackage

// File: rtl/packet_priority_arbiter.sv
// Combinational fixed-priority arbiter for data-island packet sources.
module packet_priority_arbiter
  import hdmi_packet_pkg::*;
(
  input  logic [NUM_SRC-1:0] req_i,
  input  logic               starve_i,
  output logic [NUM_SRC-1:0] grant_o
);

  logic info_any;

  assign info_any = req_i[G_AVI] | req_i[G_AIF] | req_i[G_SPD];

  // ACR always wins; a starved InfoFrame only jumps ahead of samples
  always_comb begin
    grant_o = '0;
    if (req_i[G_ACR])                               grant_o[G_ACR] = 1'b1;
    else if (req_i[G_SMP] && !(starve_i && info_any)) grant_o[G_SMP] = 1'b1;
    else if (req_i[G_AVI])                          grant_o[G_AVI] = 1'b1;
    else if (req_i[G_AIF])                          grant_o[G_AIF] = 1'b1;
    else if (req_i[G_SPD])                          grant_o[G_SPD] = 1'b1;
  end

endmodule

// File: rtl/packet_scheduler.sv
// Chooses the packet for each HDMI data-island slot: pending-flag bookkeeping,
// sample anti-starvation counting and registered packet outputs.
module packet_scheduler
  import hdmi_packet_pkg::*;
#(
  parameter int MAX_CONSECUTIVE_SAMPLES = 4
) (
  input  logic                clk_pixel,
  input  logic                reset_n,
  input  logic                frame_start,
  input  logic                packet_enable,
  input  logic                acr_req,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [HEADER_W-1:0] acr_header,
  input  logic [HEADER_W-1:0] sample_header,
  input  logic [HEADER_W-1:0] avi_header,
  input  logic [HEADER_W-1:0] aif_header,
  input  logic [HEADER_W-1:0] spd_header,
  input  sub_arr_t            acr_sub,
  input  sub_arr_t            sample_sub,
  input  sub_arr_t            avi_sub,
  input  sub_arr_t            aif_sub,
  input  sub_arr_t            spd_sub,
  output logic [HEADER_W-1:0] header,
  output sub_arr_t            sub,
  output logic [2:0]          packet_id,
  output logic [2:0]          infoframe_overrun
);

  localparam logic [3:0] RUN_MAX = 4'(MAX_CONSECUTIVE_SAMPLES);

  logic                acr_pend_q, acr_pend_d;
  logic [2:0]          info_pend_q, info_pend_d;   // {spd, aif, avi}
  logic [3:0]          sample_run_q, sample_run_d;
  logic [2:0]          overrun_q, overrun_d;
  logic [HEADER_W-1:0] header_q;
  sub_arr_t            sub_q;
  packet_id_t          id_q;

  logic                acr_live;
  logic                starve;
  logic [NUM_SRC-1:0]  req;
  logic [NUM_SRC-1:0]  grant_raw;
  logic [NUM_SRC-1:0]  grant;
  logic [HEADER_W-1:0] hdr_sel;
  sub_arr_t            sub_sel;

  assign acr_live = acr_pend_q | acr_req;
  assign starve   = (sample_run_q == RUN_MAX);
  assign req      = {info_pend_q, sample_valid, acr_live};

  packet_priority_arbiter u_arb (
    .req_i    (req),
    .starve_i (starve),
    .grant_o  (grant_raw)
  );

  assign grant        = packet_enable ? grant_raw : '0;
  assign sample_ready = reset_n & grant[G_SMP];

  always_comb begin
    acr_pend_d  = grant[G_ACR] ? 1'b0 : acr_live;
    // A frame_start re-arm overrides a same-cycle grant clear
    info_pend_d = frame_start ? 3'b111 : (info_pend_q & ~grant[G_SPD:G_AVI]);
    overrun_d   = overrun_q | ({3{frame_start}} & info_pend_q);

    // Run saturates at the limit so the starvation test stays an equality
    sample_run_d = sample_run_q;
    if (packet_enable) begin
      if (grant[G_SMP])
        sample_run_d = (sample_run_q == RUN_MAX) ? sample_run_q : sample_run_q + 4'd1;
      else
        sample_run_d = '0;
    end
  end

  always_comb begin
    hdr_sel = NULL_HEADER;
    sub_sel = '0;
    if (grant[G_ACR]) begin
      hdr_sel = acr_header;
      sub_sel = acr_sub;
    end else if (grant[G_SMP]) begin
      hdr_sel = sample_header;
      sub_sel = sample_sub;
    end else if (grant[G_AVI]) begin
      hdr_sel = avi_header;
      sub_sel = avi_sub;
    end else if (grant[G_AIF]) begin
      hdr_sel = aif_header;
      sub_sel = aif_sub;
    end else if (grant[G_SPD]) begin
      hdr_sel = spd_header;
      sub_sel = spd_sub;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acr_pend_q   <= 1'b0;
      info_pend_q  <= '0;
      sample_run_q <= '0;
      overrun_q    <= '0;
      header_q     <= NULL_HEADER;
      sub_q        <= '0;
      id_q         <= PKT_NULL;
    end else begin
      acr_pend_q   <= acr_pend_d;
      info_pend_q  <= info_pend_d;
      sample_run_q <= sample_run_d;
      overrun_q    <= overrun_d;
      if (packet_enable) begin
        header_q <= hdr_sel;
        sub_q    <= sub_sel;
        id_q     <= id_from_grant(grant);
      end
    end
  end

  assign header            = header_q;
  assign sub               = sub_q;
  assign packet_id         = id_q;
  assign infoframe_overrun = overrun_q;

endmodule

// File: tb/tb_packet_scheduler.sv
// Scoreboard bench for packet_scheduler: stimulus drives a slot-level reference
// model and queues expected packets; a monitor compares DUT outputs against them.
module tb_packet_scheduler;
  import hdmi_packet_pkg::*;

  localparam int MAXC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset_n = 1'b0;
  logic                frame_start = 1'b0, packet_enable = 1'b0;
  logic                acr_req = 1'b0, sample_valid = 1'b0;
  logic                sample_ready;
  logic [HEADER_W-1:0] acr_header = '0, sample_header = '0, avi_header = '0;
  logic [HEADER_W-1:0] aif_header = '0, spd_header = '0;
  sub_arr_t            acr_sub = '0, sample_sub = '0, avi_sub = '0, aif_sub = '0, spd_sub = '0;
  logic [HEADER_W-1:0] header;
  sub_arr_t            sub;
  logic [2:0]          packet_id;
  logic [2:0]          infoframe_overrun;

  packet_scheduler #(.MAX_CONSECUTIVE_SAMPLES(MAXC)) dut (
    .clk_pixel         (clk),
    .reset_n           (reset_n),
    .frame_start       (frame_start),
    .packet_enable     (packet_enable),
    .acr_req           (acr_req),
    .sample_valid      (sample_valid),
    .sample_ready      (sample_ready),
    .acr_header        (acr_header),
    .sample_header     (sample_header),
    .avi_header        (avi_header),
    .aif_header        (aif_header),
    .spd_header        (spd_header),
    .acr_sub           (acr_sub),
    .sample_sub        (sample_sub),
    .avi_sub           (avi_sub),
    .aif_sub           (aif_sub),
    .spd_sub           (spd_sub),
    .header            (header),
    .sub               (sub),
    .packet_id         (packet_id),
    .infoframe_overrun (infoframe_overrun)
  );

  typedef struct {
    logic [2:0]          id;
    logic [HEADER_W-1:0] hdr;
    sub_arr_t            sub;
    logic                sr;
  } exp_t;

  exp_t       expq[$];
  int         n_chk = 0;
  int         n_pass = 0;
  logic [2:0] ovr_now = '0;
  logic [2:0] ovr_next = '0;

  // Reference model state: which requests are outstanding, and how many
  // sample packets have gone out back to back.
  bit m_acr, m_avi, m_aif, m_spd;
  int m_run;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic sub_arr_t rand_sub();
    sub_arr_t   s;
    logic [63:0] w;
    for (int i = 0; i < SUB_COUNT; i++) begin
      w = {$urandom(), $urandom()};
      s[i] = w[SUB_W-1:0];
    end
    return s;
  endfunction

  task automatic model_clear();
    m_acr = 0; m_avi = 0; m_aif = 0; m_spd = 0; m_run = 0;
    ovr_next = '0; ovr_now = '0;
  endtask

  task automatic drive(input bit fs, input bit pe, input bit acr, input bit sv);
    bit   pre_avi, pre_aif, pre_spd, acr_p, starve;
    int   win;
    exp_t e;
    @(negedge clk);
    ovr_now       = ovr_next;
    frame_start   = fs;
    packet_enable = pe;
    acr_req       = acr;
    sample_valid  = sv;
    acr_header    = HEADER_W'($urandom()); acr_sub    = rand_sub();
    sample_header = HEADER_W'($urandom()); sample_sub = rand_sub();
    avi_header    = HEADER_W'($urandom()); avi_sub    = rand_sub();
    aif_header    = HEADER_W'($urandom()); aif_sub    = rand_sub();
    spd_header    = HEADER_W'($urandom()); spd_sub    = rand_sub();
    pre_avi = m_avi; pre_aif = m_aif; pre_spd = m_spd;
    acr_p = m_acr || acr;
    if (pe) begin
      starve = (m_run >= MAXC) && (m_avi || m_aif || m_spd);
      if (acr_p)               win = 1;
      else if (sv && !starve)  win = 2;
      else if (m_avi)          win = 3;
      else if (m_aif)          win = 4;
      else if (m_spd)          win = 5;
      else                     win = 0;
      e.id = 3'(win);
      e.sr = (win == 2);
      case (win)
        1:       begin e.hdr = acr_header;    e.sub = acr_sub;    end
        2:       begin e.hdr = sample_header; e.sub = sample_sub; end
        3:       begin e.hdr = avi_header;    e.sub = avi_sub;    end
        4:       begin e.hdr = aif_header;    e.sub = aif_sub;    end
        5:       begin e.hdr = spd_header;    e.sub = spd_sub;    end
        default: begin e.hdr = '0;            e.sub = '0;         end
      endcase
      expq.push_back(e);
      m_run = (win == 2) ? ((m_run < MAXC) ? m_run + 1 : m_run) : 0;
      m_acr = (win == 1) ? 1'b0 : acr_p;
      if (win == 3) m_avi = 0;
      if (win == 4) m_aif = 0;
      if (win == 5) m_spd = 0;
    end else begin
      m_acr = acr_p;
    end
    if (fs) begin
      ovr_next = ovr_next | {pre_spd, pre_aif, pre_avi};
      m_avi = 1; m_aif = 1; m_spd = 1;
    end
  endtask

  task automatic slot(input bit fs, input bit acr, input bit sv);
    repeat (31) drive(0, 0, 0, sv);
    drive(fs, 1, acr, sv);
  endtask

  // Holding packet_enable/sample_valid high during reset checks sample_ready masking
  task automatic do_reset(input int n);
    @(negedge clk);
    reset_n = 1'b0;
    frame_start = 0; acr_req = 0; packet_enable = 1; sample_valid = 1;
    model_clear();
    repeat (n) @(negedge clk);
    reset_n = 1'b1;
    packet_enable = 0; sample_valid = 0;
  endtask

  // Monitor
  initial begin
    exp_t last, e;
    last.id = '0; last.hdr = '0; last.sub = '0; last.sr = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        chk("rst_header", header, 0);
        chk("rst_sub", sub, 0);
        chk("rst_id", packet_id, 0);
        chk("rst_overrun", infoframe_overrun, 0);
        chk("rst_sample_ready", sample_ready, 0);
        last.id = '0; last.hdr = '0; last.sub = '0; last.sr = 1'b0;
      end else begin
        chk("overrun", infoframe_overrun, ovr_now);
        if (packet_enable && expq.size() > 0) begin
          e = expq.pop_front();
          chk("sample_ready", sample_ready, e.sr);
          @(posedge clk);
          #1;
          chk("packet_id", packet_id, e.id);
          chk("header", header, e.hdr);
          chk("sub", sub, e.sub);
          last = e;
        end else begin
          chk("sample_ready_idle", sample_ready, 0);
          chk("hold_id", packet_id, last.id);
          chk("hold_header", header, last.hdr);
          chk("hold_sub", sub, last.sub);
        end
      end
    end
  end

  // Stimulus
  initial begin
    model_clear();
    do_reset(3);

    // Idle slots produce null packets
    slot(0, 0, 0);
    slot(0, 0, 0);

    // ACR beats sample, then the sample goes
    drive(0, 0, 1, 1);
    slot(0, 0, 1);
    slot(0, 0, 1);
    slot(0, 1, 1);
    slot(0, 0, 1);

    // Anti-starvation sequence with samples always available
    do_reset(2);
    drive(1, 0, 0, 1);
    for (int i = 0; i < 20; i++) slot(0, 0, 1);

    // Double frame_start sets all overrun flags, which stay set
    do_reset(2);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) slot(0, 0, 0);
    chk("overrun_sticky", infoframe_overrun, 3'b111);

    // frame_start coincident with an AVI grant re-arms AVI
    do_reset(2);
    drive(1, 0, 0, 0);
    slot(1, 0, 0);
    slot(0, 0, 1);
    slot(0, 0, 0);
    slot(0, 0, 0);

    // Reset discards a pending ACR request
    drive(0, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 0);
    do_reset(3);
    slot(0, 0, 0);

    // Randomized traffic
    for (int s = 0; s < 250; s++) begin
      int gap;
      if ($urandom_range(0, 59) == 0) do_reset($urandom_range(1, 3));
      gap = $urandom_range(31, 38);
      for (int g = 0; g < gap; g++)
        drive($urandom_range(0, 299) == 0, 0, $urandom_range(0, 39) == 0,
              1'($urandom_range(0, 1)));
      drive($urandom_range(0, 7) == 0, 1, $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) != 0);
    end

    repeat (5) drive(0, 0, 0, 0);
    chk("queue_drained", 256'(expq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/packet_scheduler.md
# packet_scheduler

Selects which 32-clock data-island packet goes out in each packet slot of the HDMI transmitter. Packet sources are:
- audio clock regeneration (ACR)
- audio samples
- the AVI, audio and SPD InfoFrames
- the null packet

The block sits between the packet generators (which build header/subpacket words) and the packet assembler/TERC4 stage. It enforces fixed priority, sends each InfoFrame once per video frame, and limits consecutive sample packets so InfoFrames are not starved.

## Interface
Parameters:
- MAX_CONSECUTIVE_SAMPLES, 4: sample grants in a row after which a pending InfoFrame takes the next slot; range 1–15.

Ports:
- clk_pixel in 1: pixel clock; the only clock.
- reset_n in 1: asynchronous, active-low reset.
- frame_start in 1: one-cycle pulse, start of video frame; re-arms all InfoFrames.
- packet_enable in 1: one-cycle pulse, "latch next packet now"; consecutive pulses ≥32 cycles apart.
- acr_req in 1: one-cycle pulse, new ACR packet is due.
- sample_valid in 1: a sample packet is available.
- sample_ready out 1: sample packet consumed this cycle.
- acr_header, sample_header, avi_header, aif_header, spd_header in 24 each: source headers.
- acr_sub, sample_sub, avi_sub, aif_sub, spd_sub in [55:0] x4 each: source subpackets.
- header out 24: selected header.
- sub out [55:0] x4: selected subpackets.
- packet_id out 3: 0 null, 1 ACR, 2 sample, 3 AVI, 4 AIF, 5 SPD.
- infoframe_overrun out 3: sticky flags; bit0 AVI, bit1 AIF, bit2 SPD.

## Operation
- Pending flags: acr_pend, avi_pend, aif_pend, spd_pend; plus sample_run counter, 4 bits.
- acr_req sets acr_pend. Requests merge; no queue depth.
- frame_start sets avi/aif/spd_pend. If a flag is already set at that moment, the matching infoframe_overrun bit is set.
- Arbitration is evaluated only on packet_enable. Default priority:
  - ACR, then sample (sample_valid), then AVI, then AIF, then SPD, then null.
- Anti-starvation: if sample_run == MAX_CONSECUTIVE_SAMPLES and any InfoFrame is pending, the InfoFrame order (AVI, AIF, SPD) is used ahead of sample. ACR still wins.
- sample_run update on each packet_enable:
  - increments, saturating, on a sample grant;
  - clears on any other grant, including null.
- On a grant:
  - winner's pending flag clears;
  - header/sub/packet_id register the winner's inputs;
  - null = all-zero header and sub.
- sample_ready = packet_enable AND sample granted. It is combinational, single cycle, and the sample source advances on it.

## Timing
- Arbitration inputs in the packet_enable cycle:
  - acr_req arriving in that cycle is included (acr_pend OR acr_req);
  - sample_valid is sampled that cycle.
- frame_start coincident with packet_enable:
  - arbitration uses the pre-arm InfoFrame flags;
  - the arm wins over a same-cycle clear, so the granted InfoFrame's flag ends set;
  - overrun evaluation uses the pre-arm flags.
- acr_req coincident with an ACR grant: acr_pend ends clear, since the request is served by that grant.
- Output latency: header/sub/packet_id update on the clock edge ending the packet_enable cycle (latency 1). They hold stable until the next packet_enable.
- Source inputs are captured only at the grant edge; later changes do not affect the held packet.
- Reset values:
  - header 0, sub all 0, packet_id 0;
  - all pending flags 0, sample_run 0, infoframe_overrun 0;
  - sample_ready 0 while reset_n is low.
- Reset asserted mid-operation clears everything immediately and asynchronously. Pending requests are discarded.

## Structure
- Shared package hdmi_packet_pkg holds:
  - packet_id_t enum (NULL=0 … SPD=5);
  - NULL_HEADER constant (24'h0);
  - subpacket array width constants (4 x 56).
- Sub-module packet_priority_arbiter: purely combinational. Takes request vector {spd, aif, avi, sample, acr} and a starvation flag, and returns a one-hot grant. Instantiated once.
- Top level owns the pending flags, sample_run, output registers and overrun flags.

## Test plan
- Reset, then packet_enable with no requests: packet_id=0, header=0, sub=0, sample_ready never high.
- acr_req and sample_valid both active, then packet_enable: packet_id=1 (ACR) first. Next packet_enable: packet_id=2, sample_ready pulses once.
- frame_start, sample_valid held high, MAX_CONSECUTIVE_SAMPLES=4: packet_enable sequence gives ids 2,2,2,2,3,2,2,2,2,4,2,2,2,2,5, then all samples.
- frame_start twice with no packet_enable between: infoframe_overrun=3'b111, sticky until reset_n low.
- frame_start in the same cycle as packet_enable granting AVI: output id 3, and AVI is granted again at the next non-sample slot.
- reset_n low 3 cycles after acr_req, before packet_enable: after release, packet_enable yields id 0, and all outputs read 0 during reset.
